// File: rtl/gear_pkg.sv
// Shared definitions for the 20/32-bit gearbox pair: frame geometry, phase
// and word-index types, emit phases and the live-payload mask helper.
package gear_pkg;

    localparam int FRAME_WORDS_20 = 5;
    localparam int FRAME_WORDS_32 = 3;
    localparam int PAD_BITS       = 4;
    localparam int IN_BITS        = 20;
    localparam int OUT_BITS       = 32;
    localparam int PAYLOAD_BITS   = FRAME_WORDS_32 * OUT_BITS;

    // Deepest carry-over between accepts is word 2 plus the top nibble of word 1.
    localparam int PACK_BITS      = 24;

    typedef logic [2:0] phase_t;
    typedef logic [1:0] word_idx_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam phase_t EMIT_W0    = 3'd1;
    localparam phase_t EMIT_W1    = 3'd3;
    localparam phase_t EMIT_W2    = 3'd4;
    localparam phase_t LAST_PHASE = phase_t'(FRAME_WORDS_20 - 1);

    function automatic logic [PAYLOAD_BITS-1:0] payload_mask(input int width);
        logic [PAYLOAD_BITS-1:0] m;
        for (int i = 0; i < PAYLOAD_BITS; i++) begin
            m[i] = (i < width);
        end
        return m;
    endfunction

endpackage

// File: rtl/gear20_32.sv
// Receive-side gearbox: packs five 20-bit lane words (minus 4 pad bits)
// into three 32-bit words, tracking frame phase from a frame-start strobe.
module gear20_32
    import gear_pkg::*;
#(
    parameter int WIDTH = 96
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [19:0]     D,
    input  logic            d_valid,
    input  logic            frame_start,
    output logic [31:0]     Q,
    output logic            q_valid,
    output logic [1:0]      q_idx,
    output logic            frame_err
);

    localparam logic [PAYLOAD_BITS-1:0] MASK = payload_mask(WIDTH);

    state_t                 state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [PACK_BITS-1:0]   pack_q, pack_d;
    logic [31:0]            q_d;
    word_idx_t              idx_d;
    logic                   qv_d;
    logic                   err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            pack_q    <= '0;
            Q         <= '0;
            q_idx     <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pack_q    <= pack_d;
            Q         <= q_d;
            q_idx     <= idx_d;
            q_valid   <= qv_d;
            frame_err <= err_d;
        end
    end

    // A qualified frame_start always restarts at word 0, discarding any partial frame.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pack_d  = pack_q;
        q_d     = Q;
        idx_d   = q_idx;
        qv_d    = 1'b0;
        err_d   = 1'b0;

        if (d_valid) begin
            if (frame_start) begin
                err_d   = (state_q == RUN) && (phase_q != '0);
                state_d = RUN;
                pack_d  = {8'h00, D[IN_BITS-1:PAD_BITS]};
                phase_d = 3'd1;
            end else if (state_q == RUN) begin
                phase_d = (phase_q == LAST_PHASE) ? 3'd0 : phase_t'(phase_q + 3'd1);
                case (phase_q)
                    3'd0: begin
                        pack_d = {8'h00, D[IN_BITS-1:PAD_BITS]};
                    end
                    EMIT_W0: begin
                        q_d    = {D[15:0], pack_q[15:0]} & MASK[31:0];
                        idx_d  = 2'd0;
                        qv_d   = 1'b1;
                        pack_d = {20'h00000, D[19:16]};
                    end
                    3'd2: begin
                        pack_d = {D, pack_q[3:0]};
                    end
                    EMIT_W1: begin
                        q_d    = {D[7:0], pack_q[23:0]} & MASK[63:32];
                        idx_d  = 2'd1;
                        qv_d   = 1'b1;
                        pack_d = {12'h000, D[19:8]};
                    end
                    EMIT_W2: begin
                        q_d    = {D, pack_q[11:0]} & MASK[95:64];
                        idx_d  = 2'd2;
                        qv_d   = 1'b1;
                        pack_d = '0;
                    end
                    default: begin
                        state_d = IDLE;
                        phase_d = '0;
                        pack_d  = '0;
                    end
                endcase
            end
        end
    end

endmodule
